// File: rtl/bus_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bus_write_ctrl
// Description : Bus write-back into the processor registers, increment/clear
//               micro-ops and a three-state data-memory write sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_write_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] busin,
    input  logic [3:0]        write_en,
    input  logic [2:0]        inc_en,
    input  logic              clr_ac,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] dr,
    output logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] r,
    output logic [ADDR_W-1:0] ir,
    output logic [DATA_W-1:0] tr,
    output logic [DATA_W-1:0] ac,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [ADDR_W-1:0] dm_wdata,
    output logic              dm_we,
    output logic              wr_busy,
    output logic              wr_drop
);

    localparam logic [3:0] c_DST_PC = 4'd1;
    localparam logic [3:0] c_DST_DR = 4'd2;
    localparam logic [3:0] c_DST_AR = 4'd3;
    localparam logic [3:0] c_DST_TR = 4'd4;
    localparam logic [3:0] c_DST_AC = 4'd5;
    localparam logic [3:0] c_DST_R  = 4'd6;
    localparam logic [3:0] c_DST_DM = 4'd7;
    localparam logic [3:0] c_DST_IR = 4'd8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_WRITE = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [ADDR_W-1:0] c_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_pc, r_dr, r_ar, r_r, r_ir, r_dm_addr, r_dm_wdata;
    logic [DATA_W-1:0] r_tr, r_ac;
    logic              r_dm_we, r_wr_busy, r_wr_drop;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_dm_req;
    logic              w_accept;

    assign w_dm_req = (write_en == c_DST_DM);
    assign w_accept = w_dm_req && (r_state == c_ST_IDLE);

    // Register file: load beats increment/clear on the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
            r_dr <= '0;
            r_ar <= '0;
            r_r  <= '0;
            r_ir <= '0;
            r_tr <= '0;
            r_ac <= '0;
        end else begin
            if (write_en == c_DST_PC)      r_pc <= busin[ADDR_W-1:0];
            else if (inc_en[0])            r_pc <= r_pc + c_ONE;

            if (write_en == c_DST_AR)      r_ar <= busin[ADDR_W-1:0];
            else if (inc_en[1])            r_ar <= r_ar + c_ONE;

            if (write_en == c_DST_R)       r_r  <= busin[ADDR_W-1:0];
            else if (inc_en[2])            r_r  <= r_r + c_ONE;

            if (write_en == c_DST_AC)      r_ac <= busin;
            else if (clr_ac)               r_ac <= '0;

            if (write_en == c_DST_DR)      r_dr <= busin[ADDR_W-1:0];
            if (write_en == c_DST_TR)      r_tr <= busin;
            if (write_en == c_DST_IR)      r_ir <= busin[ADDR_W-1:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_dm_req) w_state_nxt = c_ST_WRITE;
            c_ST_WRITE: w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Strobe and busy are flopped from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_dm_we    <= 1'b0;
            r_wr_busy  <= 1'b0;
            r_wr_drop  <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dm_we   <= (w_state_nxt == c_ST_WRITE);
            r_wr_busy <= (w_state_nxt != c_ST_IDLE);
            if (w_dm_req && (r_state != c_ST_IDLE)) r_wr_drop <= 1'b1;
            if (w_accept) begin
                r_dm_addr  <= r_ar;
                r_dm_wdata <= busin[ADDR_W-1:0];
            end
        end
    end

    assign pc       = r_pc;
    assign dr       = r_dr;
    assign ar       = r_ar;
    assign r        = r_r;
    assign ir       = r_ir;
    assign tr       = r_tr;
    assign ac       = r_ac;
    assign dm_addr  = r_dm_addr;
    assign dm_wdata = r_dm_wdata;
    assign dm_we    = r_dm_we;
    assign wr_busy  = r_wr_busy;
    assign wr_drop  = r_wr_drop;

endmodule
`default_nettype wire
